// File: rtl/muxn_arb_if.sv
// Handshake bundle between N producers, the muxn_arb block and one consumer.
// The slave modport is the arbiter's view. The master modport is the producer/consumer side.
interface muxn_arb_if #(
   parameter int WIDTH    = 64,
   parameter int CHANNELS = 4
);
   localparam int SELW = $clog2(CHANNELS);

   logic [CHANNELS-1:0][WIDTH-1:0] in_data;
   logic [CHANNELS-1:0]            in_valid;
   logic [CHANNELS-1:0]            in_ready;
   logic [WIDTH-1:0]               out_data;
   logic [SELW-1:0]                out_sel;
   logic                           out_valid;
   logic                           out_ready;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_sel, out_valid
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_sel, out_valid
   );
endinterface

// File: rtl/muxn_arb.sv
// N-channel registered mux with valid/ready arbitration and a single output register stage.
// Define MUXN_ARB_RR_EN for round-robin priority; otherwise the lowest valid channel always wins.
module muxn_arb #(
   parameter int WIDTH    = 64,
   parameter int CHANNELS = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   muxn_arb_if.slave  bus
);
   localparam int SELW = $clog2(CHANNELS);

   logic [WIDTH-1:0]    r_data;
   logic [SELW-1:0]     r_sel;
   logic                r_valid;

   logic                w_load;
   logic                w_any;
   logic [SELW-1:0]     w_ptr;
   logic [SELW-1:0]     w_winner;
   logic [SELW-1:0]     w_idx [CHANNELS];
   logic [CHANNELS-1:0] w_ready;

   assign w_load = !r_valid || bus.out_ready;

   // w_idx[k] is the channel examined k-th in scan order starting at the pointer
   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_rot
      logic [SELW:0] w_sum;
      assign w_sum       = {1'b0, w_ptr} + (SELW+1)'(gi);
      assign w_idx[gi]   = (w_sum >= (SELW+1)'(CHANNELS)) ?
                           SELW'(w_sum - (SELW+1)'(CHANNELS)) : SELW'(w_sum);
   end

   always_comb begin
      w_any    = 1'b0;
      w_winner = '0;
      // Walk from the lowest-priority slot down so the first valid in scan order ends up winning
      for (int off = CHANNELS - 1; off >= 0; off--) begin
         if (bus.in_valid[w_idx[off]]) begin
            w_any    = 1'b1;
            w_winner = w_idx[off];
         end
      end
   end

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
      assign w_ready[gi] = reset_n && w_load && w_any && (w_winner == SELW'(gi));
   end

   assign bus.in_ready = w_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_sel   <= '0;
      end else if (w_load) begin
         r_valid <= w_any;
         if (w_any) begin
            r_data <= bus.in_data[w_winner];
            r_sel  <= w_winner;
         end
      end
   end

`ifdef MUXN_ARB_RR_EN
   logic [SELW-1:0] r_ptr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr <= '0;
      end else if (w_load && w_any) begin
         r_ptr <= (w_winner == SELW'(CHANNELS - 1)) ? '0 : w_winner + 1'b1;
      end
   end

   assign w_ptr = r_ptr;
`else
   assign w_ptr = '0;
`endif

   assign bus.out_data  = r_data;
   assign bus.out_sel   = r_sel;
   assign bus.out_valid = r_valid;
endmodule

// File: doc/muxn_arb.md
# muxn_arb

Parametrised N-channel registered multiplexer with valid/ready handshaking and arbitration, the sequential successor to the combinational 2:1 datapath mux. It sits between several producers (e.g. writeback sources, forwarding paths, memory-response ports) and one consumer. It picks one requesting channel per cycle, registers that channel's data and index, and holds them until the consumer accepts.

## Interface
- WIDTH, 64, data width per channel in bits (≥1)
- CHANNELS, 4, number of input channels (≥2)
- SELW, $clog2(CHANNELS), width of the channel index (derived; not to be overridden)

- clk  input  1  clock, rising edge
- reset_n  input  1  reset, asynchronous, active-low
- in_data  input  [CHANNELS-1:0][WIDTH-1:0]  per-channel data, packed array indexed by channel
- in_valid  input  CHANNELS  per-channel request
- in_ready  output  CHANNELS  per-channel accept, at most one bit high
- out_data  output  WIDTH  registered data of the granted channel
- out_sel  output  SELW  registered index of the granted channel
- out_valid  output  1  out_data/out_sel hold an unconsumed word
- out_ready  input  1  consumer accepts the word this cycle

## Operation
- One output register stage holds out_data, out_sel and out_valid.
- load = !out_valid || out_ready. A transfer on channel i occurs when in_valid[i] && in_ready[i].
- Arbitration happens only when load=1. The winner is the first channel with in_valid set, scanned from the priority pointer upward with wrap-around. in_ready[winner]=1 and all other in_ready bits are 0.
- When load=0, all in_ready bits are 0 and the register holds its contents.
- At the clock edge with load=1:
  - If any channel is valid: out_data ← in_data[winner], out_sel ← winner, out_valid ← 1.
  - If no channel is valid: out_valid ← 0, and out_data/out_sel hold their previous values.
- Priority pointer (SELW bits): after a grant to channel k, pointer ← (k+1) mod CHANNELS. With no grant, the pointer is unchanged.
- in_ready depends combinationally on in_valid and out_ready. in_ready must not depend on in_data.
- A producer must hold in_data/in_valid stable until its transfer occurs. The block never drops or duplicates a word.
- Asserting reset_n low at any time clears out_valid, out_data, out_sel and the pointer immediately. Any held word is discarded. in_ready goes to all 0 while reset_n is low.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_sel=0, pointer=0 (channel 0 highest priority).
  - in_ready=0 during reset; after release it follows the load/arbitration rules.
- Latency: 1 cycle from an accepted input to out_valid.
- Throughput: 1 word/cycle when out_ready is held high.
- Back-to-back: a word may be consumed and a new one loaded on the same edge (out_ready=1 && out_valid=1 → load=1).
- Simultaneous requests: exactly one is granted per cycle. Losers keep in_valid high and are served in later cycles.
- Wrap-around: with pointer = CHANNELS-1, the scan order is CHANNELS-1, 0, 1, …
- Consumer stall: out_valid=1 and out_ready=0 holds out_data/out_sel constant and keeps in_ready all 0 until acceptance.
- Reset release is synchronised by the integrator. The block is only required to have no grant in the first cycle after release if in_valid is low.

## Configuration
- MUXN_ARB_RR_EN defined: round-robin arbitration via the priority pointer, as described above.
- MUXN_ARB_RR_EN undefined:
  - Fixed priority; the lowest-numbered valid channel always wins.
  - The pointer register is not instantiated and is treated as constantly 0.
  - All other behaviour is identical.

## Test plan
- Reset: drive reset_n=0 mid-transfer with out_valid=1 → out_valid, out_data, out_sel and in_ready all 0 with no clock edge. After release with in_valid=0 → out_valid stays 0.
- Single channel: CHANNELS=4, WIDTH=64, in_valid=4'b0100, in_data[2]=64'hDEAD_BEEF, out_ready=1 → in_ready=4'b0100 that cycle. Next cycle out_valid=1, out_data=64'hDEAD_BEEF, out_sel=2.
- Round-robin (MUXN_ARB_RR_EN defined): all four in_valid held high, out_ready=1 → out_sel sequence 0,1,2,3,0,1 on consecutive cycles. Each in_ready bit is high exactly once per four cycles.
- Fixed priority (macro undefined): same stimulus → out_sel=0 every cycle and in_ready=4'b0001 constantly.
- Stall: load a word from channel 1, then hold out_ready=0 for 5 cycles with channels 0 and 3 valid → in_ready=0, and out_data/out_sel unchanged for all 5 cycles. Raising out_ready → the channel-1 word is consumed and, on the same edge, channel 3 loads (pointer=2 → scan order 2,3,0,1; channel 3 is first valid).
- Bubble: in_valid=0 for one cycle between two words with out_ready=1 → out_valid goes 1,0,1. The pointer is unchanged across the idle cycle.
